// File: rtl/neopixel_pkg.sv
// Shared constants for the WS2812-style LED line: default timings, pixel layout
// and the receiver state encoding.
package neopixel_pkg;

    localparam int unsigned T0H          = 30;
    localparam int unsigned T1H          = 60;
    localparam int unsigned T0L          = 90;
    localparam int unsigned T1L          = 60;
    localparam int unsigned TRST         = 8000;
    localparam int unsigned RST_DETECT   = 4000;
    localparam int unsigned T_BIT_THRESH = 45;
    localparam int unsigned T_MIN_HIGH   = 8;
    localparam int unsigned T_MAX_HIGH   = 120;

    localparam int unsigned PIXEL_WIDTH  = 24;
    localparam int unsigned PIXEL_OFFSET = 4;

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_ERROR = 3'd4
    } rx_state_e;

endpackage

// File: rtl/neopixel_line_sync.sv
// Brings the asynchronous LED line into the clk domain and flags its edges.
module neopixel_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_async,
    output logic line,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic sync;
    logic prev;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= line_async;
            sync <= meta;
            prev <= sync;
        end
    end

    assign line   = sync;
    assign rise_c = sync & ~prev;
    assign fall_c = ~sync & prev;

endmodule

// File: rtl/neopixel_receiver.sv
// Decodes the serial LED line into 24-bit pixels and writes them, followed by the
// frame pixel count at address 0, into a 32-bit memory port.
module neopixel_receiver
    import neopixel_pkg::*;
#(
    parameter int unsigned T_BIT_THRESH = neopixel_pkg::T_BIT_THRESH,
    parameter int unsigned T_MIN_HIGH   = neopixel_pkg::T_MIN_HIGH,
    parameter int unsigned T_MAX_HIGH   = neopixel_pkg::T_MAX_HIGH,
    parameter int unsigned RST_DETECT   = neopixel_pkg::RST_DETECT,
    parameter int unsigned MAX_PIXELS   = 1023,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned PIXEL_WIDTH  = neopixel_pkg::PIXEL_WIDTH,
    parameter int unsigned PIXEL_OFFSET = neopixel_pkg::PIXEL_OFFSET
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  led_data_in,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  en,
    output logic [3:0]            web,
    output logic [ADDR_WIDTH-1:0] din,
    output logic                  frame_done,
    output logic [ADDR_WIDTH-1:0] frame_pixels,
    output logic                  error,
    output logic                  busy
);

    localparam int unsigned CNT_MAX = (RST_DETECT > T_MAX_HIGH + 1) ? RST_DETECT : T_MAX_HIGH + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(PIXEL_WIDTH);
    localparam int unsigned PIX_W   = $clog2(MAX_PIXELS + 1);

    logic line;
    logic rise_c;
    logic fall_c;

    rx_state_e state;
    rx_state_e state_nx;

    logic [CNT_W-1:0]       cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [PIX_W-1:0]       pix_cnt;
    logic [PIXEL_WIDTH-2:0] shreg;
    logic [PIXEL_WIDTH-1:0] shreg_nx_c;
    logic                   ovf_seen;

    logic start_c;
    logic shift_c;
    logic bit_c;
    logic frame_end_c;
    logic err_c;
    logic pix_done_c;

    neopixel_line_sync u_line_sync (
        .clk       (clk),
        .reset     (reset),
        .line_async(led_data_in),
        .line      (line),
        .rise_c    (rise_c),
        .fall_c    (fall_c)
    );

    // cnt is the number of cycles the current level has been seen; the edge cycle counts as 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise_c || fall_c) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_W'(CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        start_c     = 1'b0;
        shift_c     = 1'b0;
        bit_c       = 1'b0;
        frame_end_c = 1'b0;
        err_c       = 1'b0;
        case (state)
            ST_SYNC: begin
                if (!line && cnt >= CNT_W'(RST_DETECT)) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rise_c) begin
                    start_c  = 1'b1;
                    state_nx = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (cnt > CNT_W'(T_MAX_HIGH)) begin
                    state_nx = ST_ERROR;
                end else if (fall_c) begin
                    if (cnt < CNT_W'(T_MIN_HIGH)) begin
                        state_nx = ST_ERROR;
                    end else begin
                        shift_c  = 1'b1;
                        bit_c    = (cnt >= CNT_W'(T_BIT_THRESH));
                        state_nx = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (rise_c) begin
                    state_nx = ST_HIGH;
                end else if (cnt >= CNT_W'(RST_DETECT)) begin
                    frame_end_c = 1'b1;
                    state_nx    = ST_IDLE;
                end
            end
            ST_ERROR: begin
                err_c    = 1'b1;
                state_nx = ST_SYNC;
            end
            default: state_nx = ST_SYNC;
        endcase
    end

    // shreg keeps the bits received so far; the pixel's last bit comes straight from bit_c.
    assign shreg_nx_c = {shreg, bit_c};
    assign pix_done_c = shift_c && (bit_cnt == BIT_W'(PIXEL_WIDTH - 1));

    // Write strobes, frame bookkeeping and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr         <= '0;
            en           <= 1'b0;
            web          <= 4'h0;
            din          <= '0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            error        <= 1'b0;
            busy         <= 1'b0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
            shreg        <= '0;
            ovf_seen     <= 1'b0;
        end else begin
            en         <= 1'b0;
            web        <= 4'h0;
            frame_done <= 1'b0;
            error      <= 1'b0;

            if (start_c) begin
                bit_cnt  <= '0;
                busy     <= 1'b1;
                ovf_seen <= 1'b0;
            end

            if (shift_c) begin
                shreg   <= shreg_nx_c[PIXEL_WIDTH-2:0];
                bit_cnt <= pix_done_c ? '0 : bit_cnt + BIT_W'(1);
            end

            if (pix_done_c) begin
                if (pix_cnt != PIX_W'(MAX_PIXELS)) begin
                    en      <= 1'b1;
                    web     <= 4'hF;
                    addr    <= ADDR_WIDTH'(PIXEL_OFFSET) * (ADDR_WIDTH'(pix_cnt) + ADDR_WIDTH'(1));
                    din     <= ADDR_WIDTH'(shreg_nx_c);
                    pix_cnt <= pix_cnt + PIX_W'(1);
                end else if (!ovf_seen) begin
                    ovf_seen <= 1'b1;
                    error    <= 1'b1;
                end
            end

            if (frame_end_c) begin
                if (bit_cnt != '0) begin
                    error <= 1'b1;
                end
                if (pix_cnt != '0) begin
                    en           <= 1'b1;
                    web          <= 4'hF;
                    addr         <= '0;
                    din          <= ADDR_WIDTH'(pix_cnt);
                    frame_done   <= 1'b1;
                    frame_pixels <= ADDR_WIDTH'(pix_cnt);
                end
                pix_cnt <= '0;
                busy    <= 1'b0;
            end

            if (err_c) begin
                error   <= 1'b1;
                pix_cnt <= '0;
                busy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neopixel_receiver.sv
// Bench for neopixel_receiver: two instances share the line, one with default capacity
// and one limited to 2 pixels, each checked against its own expected-write queue.
module tb_neopixel_receiver;
    import neopixel_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned MAX_A = 1023;
    localparam int unsigned MAX_B = 2;

    logic clk = 1'b0;
    logic reset;
    logic line;
    always #5 clk = ~clk;

    logic [AW-1:0] addr_a, din_a, fp_a, addr_b, din_b, fp_b;
    logic [3:0]    web_a, web_b;
    logic          en_a, fd_a, err_a, busy_a, en_b, fd_b, err_b, busy_b;

    neopixel_receiver #(.MAX_PIXELS(MAX_A)) dut_a (
        .clk(clk), .reset(reset), .led_data_in(line),
        .addr(addr_a), .en(en_a), .web(web_a), .din(din_a),
        .frame_done(fd_a), .frame_pixels(fp_a), .error(err_a), .busy(busy_a)
    );

    neopixel_receiver #(.MAX_PIXELS(MAX_B)) dut_b (
        .clk(clk), .reset(reset), .led_data_in(line),
        .addr(addr_b), .en(en_b), .web(web_b), .din(din_b),
        .frame_done(fd_b), .frame_pixels(fp_b), .error(err_b), .busy(busy_b)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [AW-1:0] din;
    } wr_t;

    typedef struct {
        logic [23:0] tx;
        logic [23:0] ex;
        int unsigned h0, h1, l0, l1, end_low;
    } vec_t;

    wr_t q_a[$];
    wr_t q_b[$];
    int  checks = 0, passes = 0;
    int  err_cnt_a = 0, err_cnt_b = 0, err_exp_a = 0, err_exp_b = 0;
    int  cyc = 0, last_fall_cyc = 0, last_px_cyc_a = 0;
    logic [23:0] tx_px[8];
    logic [23:0] ex_px[8];
    logic [23:0] part_pat = 24'hB3B3B3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic check_write(input string tag, input wr_t e, input logic [3:0] web,
                               input logic [AW-1:0] addr, input logic [AW-1:0] din,
                               input logic fd, input logic [AW-1:0] fp);
        chk({tag, "_web"}, 32'(web), 32'hF);
        chk({tag, "_addr"}, addr, e.addr);
        chk({tag, "_din"}, din, e.din);
        chk({tag, "_frame_done"}, 32'(fd), 32'(e.addr == '0));
        if (e.addr == '0) chk({tag, "_frame_pixels"}, fp, e.din);
    endtask

    task automatic unexpected(input string tag, input logic [AW-1:0] addr, input logic [AW-1:0] din);
        checks++;
        $display("FAIL %s_unexpected_write: got addr=%h din=%h, required no write", tag, addr, din);
    endtask

    // Scoreboard monitors: every strobe pops one expected write.
    always @(negedge clk) begin
        if (!reset) begin
            if (en_a) begin
                if (q_a.size() == 0) unexpected("a", addr_a, din_a);
                else check_write("a", q_a.pop_front(), web_a, addr_a, din_a, fd_a, fp_a);
                if (addr_a != '0) last_px_cyc_a = cyc;
            end else if (fd_a || web_a != 4'h0) begin
                checks++;
                $display("FAIL a_idle_strobe: got frame_done=%b web=%h with en=0, required 0", fd_a, web_a);
            end
            if (en_b) begin
                if (q_b.size() == 0) unexpected("b", addr_b, din_b);
                else check_write("b", q_b.pop_front(), web_b, addr_b, din_b, fd_b, fp_b);
            end else if (fd_b || web_b != 4'h0) begin
                checks++;
                $display("FAIL b_idle_strobe: got frame_done=%b web=%h with en=0, required 0", fd_b, web_b);
            end
            if (err_a) err_cnt_a++;
            if (err_b) err_cnt_b++;
        end
    end

    task automatic hold(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int unsigned h0, input int unsigned h1,
                            input int unsigned l0, input int unsigned l1);
        line = 1'b1;
        hold(b ? h1 : h0);
        line = 1'b0;
        last_fall_cyc = cyc;
        hold(b ? l1 : l0);
    endtask

    task automatic send_px(input logic [23:0] p, input int unsigned h0, input int unsigned h1,
                           input int unsigned l0, input int unsigned l1);
        for (int i = 23; i >= 0; i--) send_bit(p[i], h0, h1, l0, l1);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_a_queue_left"}, 32'(q_a.size()), 32'd0);
        chk({tag, "_b_queue_left"}, 32'(q_b.size()), 32'd0);
        chk({tag, "_a_errors"}, 32'(err_cnt_a), 32'(err_exp_a));
        chk({tag, "_b_errors"}, 32'(err_cnt_b), 32'(err_exp_b));
        chk({tag, "_a_busy"}, 32'(busy_a), 32'd0);
    endtask

    // Sends n_full pixels from tx_px, then n_part loose bits, then end_low low cycles.
    task automatic send_frame(input string tag, input int unsigned n_full, input int unsigned n_part,
                              input int unsigned h0, input int unsigned h1,
                              input int unsigned l0, input int unsigned l1, input int unsigned end_low);
        for (int unsigned i = 0; i < n_full; i++) begin
            if (i < MAX_A) q_a.push_back('{AW'(PIXEL_OFFSET * (i + 1)), AW'(ex_px[i])});
            if (i < MAX_B) q_b.push_back('{AW'(PIXEL_OFFSET * (i + 1)), AW'(ex_px[i])});
            send_px(tx_px[i], h0, h1, l0, l1);
            if (i == 0) chk({tag, "_busy_in_frame"}, 32'(busy_a), 32'd1);
        end
        if (n_full > MAX_A) err_exp_a++;
        if (n_full > MAX_B) err_exp_b++;
        for (int unsigned j = 0; j < n_part; j++) send_bit(part_pat[23 - j], h0, h1, l0, l1);
        if (n_part > 0) begin
            err_exp_a++;
            err_exp_b++;
        end
        if (n_full > 0) begin
            q_a.push_back('{AW'(0), AW'((n_full < MAX_A) ? n_full : MAX_A)});
            q_b.push_back('{AW'(0), AW'((n_full < MAX_B) ? n_full : MAX_B)});
        end
        hold(end_low);
        check_quiet(tag);
    endtask

    task automatic check_zero(input string tag, input logic en, input logic [3:0] web,
                              input logic [AW-1:0] addr, input logic [AW-1:0] din, input logic fd,
                              input logic [AW-1:0] fp, input logic err, input logic busy);
        chk({tag, "_en"}, 32'(en), 32'd0);
        chk({tag, "_web"}, 32'(web), 32'd0);
        chk({tag, "_addr"}, addr, 32'd0);
        chk({tag, "_din"}, din, 32'd0);
        chk({tag, "_frame_done"}, 32'(fd), 32'd0);
        chk({tag, "_frame_pixels"}, fp, 32'd0);
        chk({tag, "_error"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{24'h123456, 24'h123456, T0H, T1H, T0L, T1L, TRST};
        vecs[1] = '{24'hA5C3F0, 24'hA5C3F0, 44, 45, 20, 20, 4050};
        vecs[2] = '{24'hFFFFFF, 24'h000000, 44, 44, 20, 20, 4050};
        vecs[3] = '{24'h000000, 24'hFFFFFF, 45, 45, 20, 20, 4050};
        vecs[4] = '{24'h5A5A5A, 24'h5A5A5A, 8, 120, 20, 20, 4050};

        line  = 1'b0;
        reset = 1'b1;
        hold(4);
        check_zero("rst_a", en_a, web_a, addr_a, din_a, fd_a, fp_a, err_a, busy_a);
        check_zero("rst_b", en_b, web_b, addr_b, din_b, fd_b, fp_b, err_b, busy_b);
        reset = 1'b0;
        hold(RST_DETECT + 100);

        // Single-pixel frames: decoding by pulse width, threshold and width limits.
        for (int i = 0; i < 5; i++) begin
            tx_px[0] = vecs[i].tx;
            ex_px[0] = vecs[i].ex;
            send_frame($sformatf("vec%0d", i), 1, 0, vecs[i].h0, vecs[i].h1, vecs[i].l0,
                       vecs[i].l1, vecs[i].end_low);
            chk($sformatf("vec%0d_latency", i), 32'(last_px_cyc_a - last_fall_cyc), 32'd3);
        end

        // Three pixels in one frame; the 2-pixel instance overflows.
        tx_px[0] = 24'hFF0000; tx_px[1] = 24'h00FF00; tx_px[2] = 24'h0000FF;
        ex_px[0] = 24'hFF0000; ex_px[1] = 24'h00FF00; ex_px[2] = 24'h0000FF;
        send_frame("three_px", 3, 0, T0H, T1H, 20, 20, 4050);

        // Glitch mid-pixel: error, no count write, then resync and capture.
        for (int i = 0; i < 5; i++) send_bit(part_pat[23 - i], T0H, T1H, 20, 20);
        line = 1'b1;
        hold(3);
        line = 1'b0;
        err_exp_a++;
        err_exp_b++;
        hold(RST_DETECT + 100);
        check_quiet("glitch");
        tx_px[0] = 24'hC0FFEE;
        ex_px[0] = 24'hC0FFEE;
        send_frame("after_glitch", 1, 0, T0H, T1H, 20, 20, 4050);

        // Partial pixel at frame end, alone and after a full pixel.
        send_frame("partial_only", 0, 10, T0H, T1H, 20, 20, 4050);
        tx_px[0] = 24'h0F1E2D;
        ex_px[0] = 24'h0F1E2D;
        send_frame("px_plus_partial", 1, 10, T0H, T1H, 20, 20, 4050);

        // Reset mid-pixel: partial frame discarded, receiver back in SYNC.
        for (int i = 0; i < 6; i++) send_bit(part_pat[23 - i], T0H, T1H, 20, 20);
        chk("pre_reset_busy", 32'(busy_a), 32'd1);
        reset = 1'b1;
        hold(2);
        check_zero("mid_rst_a", en_a, web_a, addr_a, din_a, fd_a, fp_a, err_a, busy_a);
        check_zero("mid_rst_b", en_b, web_b, addr_b, din_b, fd_b, fp_b, err_b, busy_b);
        reset = 1'b0;
        for (int i = 6; i < 24; i++) send_bit(part_pat[23 - i], T0H, T1H, 20, 20);
        chk("sync_ignores_bits_busy_a", 32'(busy_a), 32'd0);
        chk("sync_ignores_bits_busy_b", 32'(busy_b), 32'd0);
        hold(RST_DETECT + 100);
        check_quiet("post_reset");
        tx_px[0] = 24'h7E57A1;
        ex_px[0] = 24'h7E57A1;
        send_frame("after_reset", 1, 0, T0H, T1H, 20, 20, 4050);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/neopixel_receiver.md
Name: neopixel_receiver

Overview:
Single-wire WS2812-style receiver, the inverse of the LED controller/transmitter pair. It decodes the serial LED line into 24-bit pixels, MSB first, by measuring the high-pulse width. Each decoded pixel is written into a 32-bit memory port using the same layout the controller reads: address 0 holds the pixel count, and pixel n sits at PIXEL_OFFSET*(n+1). It is used for loopback verification and as a capture front-end for chained strips.

Parameters:
T_BIT_THRESH, 45, high-time in clk cycles; a pulse at or above this value decodes as 1, below it as 0
T_MIN_HIGH, 8, shortest legal high pulse; anything shorter is a glitch and raises an error
T_MAX_HIGH, 120, longest legal high pulse; exceeding it raises an error
RST_DETECT, 4000, continuous low cycles that mark the end of a frame (latch)
MAX_PIXELS, 1023, pixel capacity per frame
ADDR_WIDTH, 32, memory address and data width
PIXEL_WIDTH, 24, bits per pixel
PIXEL_OFFSET, 4, byte stride between pixel words

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
led_data_in  in  1  asynchronous serial LED line
addr  out  ADDR_WIDTH  memory write address
en  out  1  memory enable, single-cycle strobe
web  out  4  byte write enables; 4'hF when en=1, otherwise 0
din  out  ADDR_WIDTH  write data, pixel zero-extended or pixel count
frame_done  out  1  one-cycle pulse, asserted together with the count write
frame_pixels  out  ADDR_WIDTH  count of the last completed frame; held until the next frame completes
error  out  1  one-cycle pulse on any protocol fault
busy  out  1  high from the first rising edge until the frame ends or an error occurs

Behaviour:
- Reset values: addr, en, web, din, frame_done, frame_pixels, error and busy are all 0. The state machine enters SYNC.
- Reset mid-frame: any partial frame is discarded and no memory write is issued.
- Input path: 2-flop synchronizer, then a registered edge detector. Every pulse-width count is taken on the synchronized signal.
- Counter: a single counter `cnt`, cleared on each edge and incremented on every cycle the line holds its level. It saturates at max(RST_DETECT, T_MAX_HIGH+1).
- States:
  - SYNC: wait for the line to stay low for RST_DETECT cycles, then go to IDLE. Any high level restarts the wait.
  - IDLE: on a rising edge, go to HIGH. Clear bit_cnt and set busy=1.
  - HIGH:
    - If cnt exceeds T_MAX_HIGH, go to ERROR.
    - On a falling edge with cnt < T_MIN_HIGH, go to ERROR.
    - On any other falling edge, shift bit=(cnt >= T_BIT_THRESH) into shreg MSB first, increment bit_cnt, and go to LOW.
  - LOW:
    - On a rising edge, go to HIGH.
    - When cnt reaches RST_DETECT, the frame ends:
      - If bit_cnt != 0, pulse error and drop the partial pixel.
      - If pix_cnt > 0, issue the count write.
      - Clear pix_cnt, set busy=0, go to IDLE.
  - ERROR: pulse error once, discard the frame (no count write), clear pix_cnt, go to SYNC.
- Pixel write:
  - Issued one cycle after the falling edge that completes bit PIXEL_WIDTH-1.
  - Drives en=1, web=4'hF, addr=PIXEL_OFFSET*(pix_cnt+1), din={zeros, shreg}. Then pix_cnt increments and bit_cnt clears.
  - This write is a registered strobe issued in parallel with the state machine; it does not occupy a state.
- Count write:
  - Issued one cycle after the frame end is detected.
  - Drives en=1, web=4'hF, addr=0, din=pix_cnt. frame_done=1 and frame_pixels=pix_cnt in the same cycle.
- Overflow: when pix_cnt == MAX_PIXELS and another pixel completes, that pixel is not written and error pulses once per frame. The frame still ends normally and reports count MAX_PIXELS.
- Arithmetic: address is computed at ADDR_WIDTH width and wraps modulo 2^ADDR_WIDTH (unreachable under legal parameters).
- Exact threshold: a high of exactly T_BIT_THRESH cycles decodes as 1.
- Latency: a pixel appears on the memory port 3 cycles after its last falling edge on the raw pin (2 synchronizer cycles plus 1 registered write).

Decomposition:
- Shared package neopixel_pkg holds:
  - default timing constants (T0H/T1H/T0L/T1L/TRST, RST_DETECT, T_BIT_THRESH);
  - PIXEL_WIDTH and PIXEL_OFFSET;
  - the receiver state encoding constants.
- One sub-module, neopixel_line_sync, contains the 2-flop synchronizer plus rise/fall edge pulses.
- The pulse measurement, state machine and write logic stay in neopixel_receiver.

Test Plan:
1. Transmitter timings (T0H=30, T1H=60, T0L=90, T1L=60), send pixel 24'h123456, then 8000 low -> write addr=4, din=32'h00123456. Then write addr=0, din=1, frame_done=1, frame_pixels=1.
2. Three pixels 24'hFF0000, 24'h00FF00, 24'h0000FF -> writes at addr 4, 8, 12 with matching din, then addr=0 din=3. No error pulse.
3. High pulses of exactly 45 and 44 cycles -> decoded as 1 and 0 respectively (check the shreg MSBs via the written pixel).
4. 3-cycle glitch high mid-pixel -> error pulses once and no count write follows. After 4000 low cycles the next valid pixel is captured at addr 4.
5. Send 10 bits, then 8000 low -> error pulse, no pixel write, no count write. With one full pixel before the partial bits -> count write din=1 plus an error pulse.
6. MAX_PIXELS=2, send 3 pixels -> only addr 4 and 8 written, a single error pulse, count write din=2. Separately, assert reset mid-pixel -> outputs zero, no writes, and the block re-enters SYNC.
